// File: rtl/adc_arbiter_pkg.sv
// Shared types and constants for the A/D converter arbiter.
// Holds the sequencer state encoding, requester count and default timeout.
package adc_arbiter_pkg;

  localparam int NREQ            = 2;
  localparam int TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

endpackage

// File: rtl/adc_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: a lone requester wins outright,
// a tie goes to the requester that was not served last.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant,
  output logic       valid
);

  always_comb begin
    valid = |req;
    grant = 1'b0;
    unique case (req)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/adc_arbiter.sv
// Shares one 8-bit A/D converter between two four-phase requesters: round-robin
// grant, soc/eoc sequencing with per-phase timeout, latched sample return.
module adc_arbiter
  import adc_arbiter_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] ack,
  output logic [7:0]      dout,
  output logic            err,
  output logic            soc,
  input  logic            eoc,
  input  logic [7:0]      x
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          grant_reg, grant_next;
  logic          last_reg, last_next;
  logic [7:0]    dout_reg, dout_next;
  logic          err_reg, err_next;

  logic          pick_grant;
  logic          pick_valid;
  logic [CW-1:0] cnt_inc;
  logic          timeout_hit;
  logic          ack_en;

  rr_pick2 u_pick (
    .req   (req),
    .last  (last_reg),
    .grant (pick_grant),
    .valid (pick_valid)
  );

  // The counter holds cycles already spent in the phase, so the abort edge is
  // the one on which the count would reach TIMEOUT.
  assign cnt_inc     = cnt_reg + CW'(1);
  assign timeout_hit = (cnt_inc == CW'(TIMEOUT));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      grant_reg <= 1'b0;
      last_reg  <= 1'b1;
      dout_reg  <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      grant_reg <= grant_next;
      last_reg  <= last_next;
      dout_reg  <= dout_next;
      err_reg   <= err_next;
    end
  end

  // An awaited eoc level seen on the abort edge still wins over the timeout.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    grant_next = grant_reg;
    last_next  = last_reg;
    dout_next  = dout_reg;
    err_next   = err_reg;
    unique case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          state_next = START;
          grant_next = pick_grant;
          last_next  = pick_grant;
          cnt_next   = '0;
        end
      end
      START: begin
        if (!eoc) begin
          state_next = WAIT;
          cnt_next   = '0;
        end else if (timeout_hit) begin
          state_next = ACK;
          err_next   = 1'b1;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      WAIT: begin
        if (eoc) begin
          state_next = ACK;
          dout_next  = x;
          err_next   = 1'b0;
        end else if (timeout_hit) begin
          state_next = ACK;
          err_next   = 1'b1;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      ACK: begin
        if (!req[grant_reg]) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    soc    = 1'b0;
    ack_en = 1'b0;
    unique case (state_reg)
      START:   soc    = 1'b1;
      ACK:     ack_en = 1'b1;
      default: ;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_ack
      assign ack[gi] = ack_en && (grant_reg == 1'(gi));
    end
  endgenerate

  assign dout = dout_reg;
  assign err  = err_reg;

endmodule

// File: tb/tb_adc_arbiter.sv
// Self-checking bench for adc_arbiter: directed vector table, reset corner case,
// then randomized transactions against a transaction-level reference model.
module tb_adc_arbiter;

  localparam int TO = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] req   = 2'b00;
  logic       eoc   = 1'b1;
  logic [7:0] x     = 8'h00;
  logic [1:0] ack;
  logic [7:0] dout;
  logic       err;
  logic       soc;

  int total = 0;
  int bad   = 0;

  logic       last_m;
  logic [7:0] dout_m;

  typedef struct {
    logic [1:0] r;
    int         dd;
    int         dr;
    logic [7:0] xv;
    bit         early;
    logic       g;
    logic [7:0] dout;
    bit         err;
    int         lat;
  } vec_t;

  vec_t tbl[12];

  adc_arbiter #(.TIMEOUT(TO)) dut (
    .clock (clock),
    .reset (reset),
    .req   (req),
    .ack   (ack),
    .dout  (dout),
    .err   (err),
    .soc   (soc),
    .eoc   (eoc),
    .x     (x)
  );

  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Converter pulls eoc low so it is sampled low dd edges after the grant edge,
  // and high again dr edges later; x is only valid on that rising sample.
  task automatic txn(input logic [1:0] r, input int dd, input int dr, input logic [7:0] xv,
                     input bit early, input bit raise_other, input logic g,
                     input logic [7:0] exp_dout, input bit exp_err, input int exp_lat);
    int soc_len;
    bit early_eff;
    int hold;
    soc_len   = (dd < TO) ? dd : TO;
    early_eff = early && (soc_len < exp_lat);
    req = r;
    for (int k = 0; k <= exp_lat; k++) begin
      eoc = !(k >= dd && k < dd + dr);
      x   = (k == dd + dr) ? xv : 8'($urandom);
      tick();
      if (k < exp_lat) begin
        check("soc", int'(soc), int'(k < soc_len));
        check("ack_low", int'(ack), 0);
      end
      if (early_eff && k == soc_len) req[g] = 1'b0;
      if (raise_other && k == 1) req[!g] = 1'b1;
    end
    check("ack_rise", int'(ack), int'(1) << g);
    check("dout", int'(dout), int'(exp_dout));
    check("err", int'(err), int'(exp_err));
    check("soc_ack", int'(soc), 0);
    eoc = 1'b1;
    if (!early_eff) begin
      hold = $urandom_range(0, 2);
      repeat (hold) begin
        tick();
        check("ack_hold", int'(ack), int'(1) << g);
      end
      req[g] = 1'b0;
    end
    tick();
    check("ack_fall", int'(ack), 0);
    check("dout_keep", int'(dout), int'(exp_dout));
    check("err_keep", int'(err), int'(exp_err));
    $display("txn req=%b g=%0d dd=%0d dr=%0d lat=%0d dout=%02h err=%0d early=%0d",
             r, g, dd, dr, exp_lat, exp_dout, exp_err, early_eff);
  endtask

  function automatic int model_lat(input int dd, input int dr);
    if (dd > TO) return TO;
    if (dr > TO) return dd + TO;
    return dd + dr;
  endfunction

  initial begin
    logic [1:0] r;
    logic       g;
    int         dd;
    int         dr;
    int         lat;
    bit         e;
    logic [7:0] xv;

    tbl[0]  = '{2'b11,  1,  1, 8'h10, 1'b0, 1'b0, 8'h10, 1'b0,  2};
    tbl[1]  = '{2'b11,  1,  1, 8'h20, 1'b0, 1'b1, 8'h20, 1'b0,  2};
    tbl[2]  = '{2'b11,  2,  1, 8'h30, 1'b0, 1'b0, 8'h30, 1'b0,  3};
    tbl[3]  = '{2'b11,  1,  2, 8'h40, 1'b0, 1'b1, 8'h40, 1'b0,  3};
    tbl[4]  = '{2'b01,  2,  3, 8'h5A, 1'b0, 1'b0, 8'h5A, 1'b0,  5};
    tbl[5]  = '{2'b01, 99,  0, 8'h77, 1'b0, 1'b0, 8'h5A, 1'b1,  8};
    tbl[6]  = '{2'b10,  2, 99, 8'h66, 1'b0, 1'b1, 8'h5A, 1'b1, 10};
    tbl[7]  = '{2'b10,  2,  2, 8'hC3, 1'b1, 1'b1, 8'hC3, 1'b0,  4};
    tbl[8]  = '{2'b01,  7,  8, 8'hE1, 1'b0, 1'b0, 8'hE1, 1'b0, 15};
    tbl[9]  = '{2'b01,  8,  3, 8'h12, 1'b0, 1'b0, 8'h12, 1'b0, 11};
    tbl[10] = '{2'b01,  9,  1, 8'h34, 1'b0, 1'b0, 8'h12, 1'b1,  8};
    tbl[11] = '{2'b10,  1,  9, 8'h56, 1'b0, 1'b1, 8'h12, 1'b1,  9};

    repeat (3) tick();
    check("rst_soc", int'(soc), 0);
    check("rst_ack", int'(ack), 0);
    check("rst_dout", int'(dout), 0);
    check("rst_err", int'(err), 0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 12; i++)
      txn(tbl[i].r, tbl[i].dd, tbl[i].dr, tbl[i].xv, tbl[i].early, 1'b0,
          tbl[i].g, tbl[i].dout, tbl[i].err, tbl[i].lat);

    // Reset while waiting for eoc: grant abandoned, soc low, last back to 1.
    req = 2'b10;
    eoc = 1'b1;
    tick();
    check("pre_rst_soc", int'(soc), 1);
    eoc = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("mid_rst_soc", int'(soc), 0);
    check("mid_rst_ack", int'(ack), 0);
    check("mid_rst_dout", int'(dout), 0);
    check("mid_rst_err", int'(err), 0);
    reset = 1'b0;
    req   = 2'b00;
    tick();
    eoc = 1'b1;
    tick();
    check("idle_soc", int'(soc), 0);
    txn(2'b11, 1, 1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 2);

    last_m = 1'b0;
    dout_m = 8'hA5;
    for (int n = 0; n < 40; n++) begin
      r = req | 2'($urandom_range(0, 3));
      if (r == 2'b00) r = 2'($urandom_range(1, 3));
      g      = (r == 2'b11) ? !last_m : r[1];
      last_m = g;
      dd     = $urandom_range(1, 10);
      dr     = $urandom_range(1, 10);
      lat    = model_lat(dd, dr);
      e      = (dd > TO) || (dr > TO);
      xv     = 8'($urandom);
      if (!e) dout_m = xv;
      txn(r, dd, dr, xv, ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
          g, dout_m, e, lat);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
